// File: rtl/ramdisk_axi_pkg.sv
// ramdisk_axi_pkg
//   Shared definitions for the block-RAM backed AXI4 slave: burst and
//   response codes, the only accepted transfer size, the controller state
//   type and a helper that classifies an address request as unsupported.
package ramdisk_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RPREF,
        ST_RDATA
    } state_t;

    // Anything other than 32-bit INCR is served (beats are consumed or
    // returned) but flagged with SLVERR and never modifies memory.
    function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_4B) || (burst != BURST_INCR);
    endfunction

endpackage

// File: rtl/ramdisk_bram.sv
// ramdisk_bram
//   Single-port 32-bit block RAM, depth 2**AW words, four byte-write
//   enables, registered (1-cycle) read. The read register only updates
//   when en is high, so it holds its word while the port is idle.
//   Contents are never cleared.
// Ports:
//   clk   rising-edge clock
//   en    port enable (read and/or write this cycle)
//   we    byte write enables, only honoured with en
//   addr  word address
//   din   write data
//   dout  registered read data (read-before-write)
import ramdisk_axi_pkg::*;

module ramdisk_bram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= din[8*b +: 8];
                end
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/ramdisk_axi_slave.sv
// ramdisk_axi_slave
//   AXI4 slave backed by on-chip block RAM. Serves 32-bit INCR bursts of
//   1..256 beats, one transaction at a time, with write/read arbitration
//   that alternates when both address channels request together.
//   Optional: define RAMDISK_AXI_SLAVE_STATS_EN to build the completed
//   burst counters; otherwise write_bursts/read_bursts are constant 0.
// Ports:
//   ui_clk, ui_rst_n        clock, asynchronous active-low reset
//   s_axi_aw* / s_axi_w*    write address and data channels
//   s_axi_b*                write response channel
//   s_axi_ar* / s_axi_r*    read address and data channels
//   write_bursts/read_bursts  completed burst counters (16-bit, wrapping)
import ramdisk_axi_pkg::*;

module ramdisk_axi_slave #(
    parameter int ADDR_W = 28,
    parameter int MEM_AW = 14,
    parameter int ID_W   = 4
) (
    input  logic              ui_clk,
    input  logic              ui_rst_n,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [15:0]       write_bursts,
    output logic [15:0]       read_bursts
);

    state_t              state, state_nx;
    logic                prio_w;
    logic [ID_W-1:0]     cap_id;
    logic [7:0]          cap_len;
    logic [MEM_AW-1:0]   ptr;
    logic [8:0]          icnt;      // write beats taken / read words issued
    logic [8:0]          ocnt;      // read beats handed over
    logic                err;

    // Read output: the RAM read register is the output stage (valid = av);
    // the skid holds the older word when a new read lands while the
    // current one is still waiting for rready.
    logic                av;
    logic                sk_v;
    logic [31:0]         sk_d;

    logic                aw_go, ar_go, w_beat, w_last, r_fire, rd_issue;
    logic                ram_en;
    logic [3:0]          ram_we;
    logic [31:0]         ram_dout;

    logic                unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[ADDR_W-1:MEM_AW+2], s_axi_awaddr[1:0],
                                s_axi_araddr[ADDR_W-1:MEM_AW+2], s_axi_araddr[1:0]};

    ramdisk_bram #(.AW(MEM_AW)) u_bram (
        .clk  (ui_clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ptr),
        .din  (s_axi_wdata),
        .dout (ram_dout)
    );

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) state <= ST_IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        s_axi_bid     = cap_id;
        s_axi_rid     = cap_id;
        s_axi_rvalid  = sk_v | av;
        s_axi_rdata   = sk_v ? sk_d : (av ? ram_dout : '0);
        s_axi_rlast   = (sk_v | av) && (ocnt == {1'b0, cap_len});
        s_axi_rresp   = ((sk_v | av) && err) ? RESP_SLVERR : RESP_OKAY;
        rd_issue      = 1'b0;

        case (state)
            ST_IDLE: begin
                s_axi_awready = s_axi_awvalid & (~s_axi_arvalid | prio_w);
                s_axi_arready = s_axi_arvalid & (~s_axi_awvalid | ~prio_w);
                if (s_axi_awready)      state_nx = ST_WDATA;
                else if (s_axi_arready) state_nx = ST_RPREF;
            end
            ST_WDATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && icnt == {1'b0, cap_len}) state_nx = ST_WRESP;
            end
            ST_WRESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = err ? RESP_SLVERR : RESP_OKAY;
                if (s_axi_bready) state_nx = ST_IDLE;
            end
            ST_RPREF: begin
                rd_issue = 1'b1;
                state_nx = ST_RDATA;
            end
            ST_RDATA: begin
                rd_issue = ~sk_v && (icnt <= {1'b0, cap_len});
                if (s_axi_rvalid && s_axi_rready && s_axi_rlast) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        aw_go  = s_axi_awvalid & s_axi_awready;
        ar_go  = s_axi_arvalid & s_axi_arready;
        w_beat = s_axi_wvalid & s_axi_wready;
        w_last = (icnt == {1'b0, cap_len});
        r_fire = s_axi_rvalid & s_axi_rready;
        ram_en = w_beat | rd_issue;
        ram_we = (w_beat && !err) ? s_axi_wstrb : 4'b0000;
    end

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            prio_w  <= 1'b1;
            cap_id  <= '0;
            cap_len <= '0;
            ptr     <= '0;
            icnt    <= '0;
            ocnt    <= '0;
            err     <= 1'b0;
            av      <= 1'b0;
            sk_v    <= 1'b0;
            sk_d    <= '0;
        end else begin
            if (aw_go) begin
                prio_w  <= 1'b0;
                cap_id  <= s_axi_awid;
                cap_len <= s_axi_awlen;
                ptr     <= s_axi_awaddr[MEM_AW+1:2];
                err     <= req_err(s_axi_awsize, s_axi_awburst);
                icnt    <= '0;
                ocnt    <= '0;
            end else if (ar_go) begin
                prio_w  <= 1'b1;
                cap_id  <= s_axi_arid;
                cap_len <= s_axi_arlen;
                ptr     <= s_axi_araddr[MEM_AW+1:2];
                err     <= req_err(s_axi_arsize, s_axi_arburst);
                icnt    <= '0;
                ocnt    <= '0;
            end

            if (w_beat) begin
                ptr  <= ptr + 1'b1;
                icnt <= icnt + 1'b1;
                // wlast must coincide exactly with the final beat
                if (w_last != s_axi_wlast) err <= 1'b1;
            end

            if (rd_issue) begin
                ptr  <= ptr + 1'b1;
                icnt <= icnt + 1'b1;
            end

            if (r_fire) ocnt <= ocnt + 1'b1;

            if (sk_v) begin
                if (r_fire) sk_v <= 1'b0;
            end else if (rd_issue) begin
                av <= 1'b1;
                // the word on the output is about to be overwritten by the
                // RAM register: park it so the output stays stable
                if (av && !r_fire) begin
                    sk_v <= 1'b1;
                    sk_d <= ram_dout;
                end
            end else if (r_fire) begin
                av <= 1'b0;
            end

            if (r_fire && s_axi_rlast) begin
                av   <= 1'b0;
                sk_v <= 1'b0;
            end
        end
    end

`ifdef RAMDISK_AXI_SLAVE_STATS_EN
    logic [15:0] wb_cnt, rb_cnt;

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            wb_cnt <= '0;
            rb_cnt <= '0;
        end else begin
            if (s_axi_bvalid && s_axi_bready)  wb_cnt <= wb_cnt + 16'd1;
            if (r_fire && s_axi_rlast)         rb_cnt <= rb_cnt + 16'd1;
        end
    end

    assign write_bursts = wb_cnt;
    assign read_bursts  = rb_cnt;
`else
    assign write_bursts = '0;
    assign read_bursts  = '0;
`endif

endmodule

// File: doc/ramdisk_axi_slave.md
Name: ramdisk_axi_slave

Overview:
- AXI4 slave (responder) backed by on-chip block RAM; the target-side counterpart of the RAM-disk AXI4 master.
- Serves 32-bit INCR bursts of up to 256 beats. One outstanding transaction at a time: write or read.
- Used as an FPGA-internal RAM disk store when no SDRAM is fitted, and as the bench model behind the SDRAM ramdisk master.

Parameters:
- ADDR_W, 28, AXI byte-address width (awaddr/araddr).
- MEM_AW, 14, log2 of memory depth in 32-bit words (default 16K words = 64 KiB).
- ID_W, 4, AXI ID width.

Ports:
- ui_clk  in  1  clock, all logic rising-edge.
- ui_rst_n  in  1  asynchronous active-low reset.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address channel.
- s_axi_awvalid  in  1;  s_axi_awready  out  1.
- s_axi_wdata/wstrb/wlast/wvalid  in  32/4/1/1;  s_axi_wready  out  1.
- s_axi_bid  out  ID_W;  s_axi_bresp  out  2;  s_axi_bvalid  out  1;  s_axi_bready  in  1.
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2  read address channel.
- s_axi_arvalid  in  1;  s_axi_arready  out  1.
- s_axi_rid  out  ID_W;  s_axi_rdata  out  32;  s_axi_rresp  out  2;  s_axi_rlast  out  1;  s_axi_rvalid  out  1;  s_axi_rready  in  1.
- write_bursts, read_bursts  out  16  completed-burst counters (see Optional Feature).
- lock/cache/prot/qos inputs are not present on this block; the master's constant outputs are left unconnected.

Behaviour:
- Reset: all valid and ready outputs are 0. bresp, rresp, rdata, bid and rid are 0. State is IDLE. Arbitration priority points to write. Reset is async-asserted and sync-deasserted by the integrator. Memory contents are not cleared.
- Reset mid-burst aborts the transaction: no B or further R beats are issued. Words already written are retained.
- States: IDLE, WDATA, WRESP, RPREF, RDATA.
- IDLE arbitration:
  - awready = IDLE & awvalid & (~arvalid | prio_w).
  - arready = IDLE & arvalid & (~awvalid | ~prio_w).
  - These are combinational from registered state. The handshake completes in the same cycle.
  - On a grant, prio_w is set to prefer the other direction next time, so simultaneous requests alternate.
- On an address handshake, capture id, len, word pointer = addr[MEM_AW+1:2], and err.
  - err = (size != 3'b010) | (burst != 2'b01).
  - addr[1:0] is ignored. Beat count is cleared.
  - Next state: WDATA for a write, RPREF for a read.
- WDATA:
  - wready = 1.
  - Each wvalid&wready beat writes mem[ptr] under wstrb byte enables, unless err.
  - ptr increments modulo 2^MEM_AW (wraps silently); count increments.
  - The burst ends on beat len+1. If wlast is not 1 on that beat, or is 1 earlier, err is set; early wlast does not end the burst.
  - Then move to WRESP.
- WRESP: bvalid = 1, bid = captured id, bresp = err ? 2'b10 (SLVERR) : 2'b00 (OKAY). Hold until bready, then go to IDLE.
- Read pipeline: the RAM has a 1-cycle registered read.
  - RPREF issues the first RAM read.
  - The first rvalid appears 2 cycles after the AR handshake.
  - The RDATA output stage plus a 1-entry skid register sustain one beat per cycle while rready = 1.
  - rvalid, rdata, rlast, rresp and rid hold stable while rready = 0.
  - rlast = 1 on beat len+1. rresp = err ? SLVERR : OKAY on every beat; data is still returned.
  - After the rlast handshake, go to IDLE.
- Address wrap: ptr 2^MEM_AW-1 + 1 gives 0. 4 KiB boundary crossing is not checked.
- awlen = 0 gives a single-beat burst. awlen = 255 gives 256 beats; count is 9 bits.

Optional Feature:
- Macro RAMDISK_AXI_SLAVE_STATS_EN.
- Defined: write_bursts increments on each B handshake and read_bursts on each rlast handshake. Both are 16-bit, wrap at 0xFFFF to 0, and reset to 0.
- Undefined: both outputs are constant 0 and no counter logic is built.

Decomposition:
- Package ramdisk_axi_pkg holds:
  - burst codes: FIXED=2'b00, INCR=2'b01;
  - resp codes: OKAY=2'b00, SLVERR=2'b10;
  - SIZE_4B = 3'b010;
  - the state enum.
- Sub-module ramdisk_bram: single-port, 32-bit, 4 byte-enables, registered read, depth 2^MEM_AW.

Test Plan:
- AW id=3 addr=0x200 len=127, 128 beats data=i, wlast on beat 128 → one B with bid=3 bresp=OKAY. AR same addr len=127 → 128 beats rdata=i, rlast only on beat 128, first rvalid 2 cycles after arready.
- Write 0xAABBCCDD to word 5, then 1 beat wstrb=4'b0101 data=0x11223344 → read of word 5 returns 0xAA22CC44.
- Read len=15 with rready toggling 1/0 each cycle → 16 beats, data in order, no beat lost or duplicated, outputs stable while rready=0.
- awvalid and arvalid asserted together in IDLE three times → grants in order write, read, write.
- awsize=3'b001, then awburst=FIXED, len=3 → 4 wready beats, bresp=SLVERR, memory unchanged. Read of word 0 len=0 with wlast missing on the last write beat → that write's bresp=SLVERR.
- Deassert ui_rst_n at beat 10 of a 128-beat read → rvalid=0 asynchronously. After release, AR len=0 completes with OKAY. With STATS_EN, after 2 writes and 3 reads → write_bursts=2, read_bursts=3.
